twiddle_seq_stage_8: RTL

TWIDDLE_SEQ_STAGE_8 -- requirements
Module: twiddle_seq_stage_8

---
 rtl/fft_pkg.sv | 14 +
 rtl/twiddle_skid_buf.sv | 59 +++++
 rtl/twiddle_seq_stage_8.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants and the twiddle sequencer state type
package fft_pkg;

  localparam int FFT_ANGLE_W = 32;
  localparam int FFT_ADDR_W  = 7;
  localparam int FFT_N_TW    = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tw_state_e;

endpackage

// File: rtl/twiddle_skid_buf.sv
// rtl/twiddle_skid_buf.sv - 2-entry FIFO holding ROM words tagged with their twiddle index
module twiddle_skid_buf #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]  i_index,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_index,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_data  [2];
  logic [IDX_W-1:0]  r_index [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data[0]  <= '0;
      r_data[1]  <= '0;
      r_index[0] <= '0;
      r_index[1] <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr]  <= i_data;
        r_index[r_wr_ptr] <= i_index;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_data[r_rd_ptr];
  assign o_index = r_index[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/twiddle_seq_stage_8.sv
// rtl/twiddle_seq_stage_8.sv - stage-8 twiddle ROM sequencer feeding the CORDIC rotator
// TWIDDLE_CONJ_EN adds i_inverse, which negates ROM words for IFFT frames.
module twiddle_seq_stage_8
  import fft_pkg::*;
#(
  parameter int N_TW    = FFT_N_TW,
  parameter int ANGLE_W = FFT_ANGLE_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
`ifdef TWIDDLE_CONJ_EN
  input  logic                  i_inverse,
`endif
  output logic [FFT_ADDR_W-1:0] o_rom_addr,
  input  logic [ANGLE_W-1:0]    i_rom_data,
  output logic [ANGLE_W-1:0]    o_angle,
  output logic [FFT_ADDR_W-1:0] o_index,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [FFT_ADDR_W-1:0] LAST_K = FFT_ADDR_W'(N_TW - 1);

  tw_state_e             r_state;
  tw_state_e             w_next_state;
  logic [FFT_ADDR_W-1:0] r_k;
  logic [FFT_ADDR_W-1:0] r_rom_addr;
  logic [FFT_ADDR_W-1:0] r_flight_k;
  logic                  r_inflight;
  logic                  r_done;
  logic                  w_issue;
  logic                  w_busy;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_drained;
  logic [1:0]            w_count;
  logic [1:0]            w_occ;
  logic [ANGLE_W-1:0]    w_push_data;

  assign o_valid = (w_count != 2'd0);
  assign w_pop   = o_valid && i_ready;
  assign w_occ   = w_count - {1'b0, w_pop};

  // Counting the word leaving this cycle keeps the pipe at one beat per cycle.
  assign w_room    = (w_occ == 2'd0) || ((w_occ == 2'd1) && !r_inflight);
  assign w_drained = (w_occ == 2'd0) && !r_inflight;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_RUN;
      ST_RUN:   if (w_issue && (r_k == LAST_K)) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_drained) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // k=0 is read in the start cycle itself so the first beat follows two cycles later.
  always_comb begin
    w_issue = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_issue = i_start;
      end
      ST_RUN: begin
        w_issue = w_room;
        w_busy  = 1'b1;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
      end
      default: begin
        w_issue = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_k        <= '0;
      r_rom_addr <= '0;
      r_flight_k <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= (r_state == ST_DRAIN) && w_drained;
      if (w_issue) begin
        r_rom_addr <= r_k;
        r_flight_k <= r_k;
        r_k        <= (r_k == LAST_K) ? '0 : r_k + FFT_ADDR_W'(1);
      end
    end
  end

  assign o_rom_addr = w_issue ? r_k : r_rom_addr;
  assign o_busy     = w_busy;
  assign o_done     = r_done;

`ifdef TWIDDLE_CONJ_EN
  logic r_inverse;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inverse <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_inverse <= i_inverse;
    end
  end

  assign w_push_data = r_inverse ? -i_rom_data : i_rom_data;
`else
  assign w_push_data = i_rom_data;
`endif

  twiddle_skid_buf #(
    .DATA_W (ANGLE_W),
    .IDX_W  (FFT_ADDR_W)
  ) u_skid_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_data  (w_push_data),
    .i_index (r_flight_k),
    .i_pop   (w_pop),
    .o_data  (o_angle),
    .o_index (o_index),
    .o_count (w_count)
  );

endmodule
